serial_frame_tx: RTL

Serial frame transmitter that produces the bitstream our serial pattern detectors consume. It accepts a parallel data word over a valid/ready handshake and shifts out one frame on a single-bit line: sync pattern, then payload, then an optional parity bit, then idle gap bits. It sits upstream of the detector and is used on-chip for loopback tests and link bring-up.

---
 rtl/serial_frame_tx.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - serial frame transmitter (sync, payload, parity, gap)
//
// Accepts one DATA_W word per valid/ready handshake and shifts it out on dout
// as: SYNC_PATTERN (MSB first), payload (MSB first), optional even parity,
// then GAP_BITS idle periods. Each bit is held for CLKS_PER_BIT cycles.
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - synchronous active-low reset
//   in_data    - payload word, held by upstream until accepted
//   in_valid   - in_data is valid
//   in_ready   - word can be accepted this cycle (registered)
//   dout       - serial output bit (registered)
//   busy       - frame in progress (registered)
//   frame_done - one-cycle pulse in the first idle cycle after a frame
module serial_frame_tx #(
  parameter int                DATA_W       = 8,
  parameter int                SYNC_W       = 4,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = 4'b0110,
  parameter int                PARITY_EN    = 1,
  parameter int                GAP_BITS     = 2,
  parameter int                CLKS_PER_BIT = 1,
  parameter logic              IDLE_LEVEL   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              dout,
  output logic              busy,
  output logic              frame_done
);

  localparam int MAX_SD = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int MAX_W  = (MAX_SD > GAP_BITS) ? MAX_SD : GAP_BITS;
  localparam int IDX_W  = $clog2(MAX_W + 1);
  localparam int CNT_W  = $clog2(CLKS_PER_BIT + 1);

  localparam logic [IDX_W-1:0] SYNC_LAST = IDX_W'(SYNC_W - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
  // Only meaningful when GAP_BITS > 0; the GAP state is never entered otherwise.
  localparam logic [IDX_W-1:0] GAP_LAST  = IDX_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_PARITY,
    S_GAP
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  bit_idx;
  logic [CNT_W-1:0]  clk_cnt;
  logic [SYNC_W-1:0] sync_sr;
  logic [DATA_W-1:0] data_sr;
  logic              parity;

  // dout always holds the bit currently on the line; the shift registers hold
  // the bits still to come, so each bit boundary loads the next MSB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      bit_idx    <= '0;
      clk_cnt    <= '0;
      sync_sr    <= '0;
      data_sr    <= '0;
      parity     <= 1'b0;
      dout       <= IDLE_LEVEL;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state == S_IDLE) begin
        dout     <= IDLE_LEVEL;
        busy     <= 1'b0;
        in_ready <= 1'b1;
        bit_idx  <= '0;
        clk_cnt  <= '0;
        if (in_valid && in_ready) begin
          data_sr  <= in_data;
          parity   <= ^in_data;
          sync_sr  <= SYNC_PATTERN << 1;
          dout     <= SYNC_PATTERN[SYNC_W-1];
          state    <= S_SYNC;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
      end else if (clk_cnt != CNT_LAST) begin
        clk_cnt <= clk_cnt + CNT_W'(1);
      end else begin
        clk_cnt <= '0;
        case (state)
          S_SYNC: begin
            if (bit_idx == SYNC_LAST) begin
              state   <= S_DATA;
              bit_idx <= '0;
              dout    <= data_sr[DATA_W-1];
              data_sr <= data_sr << 1;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
              dout    <= sync_sr[SYNC_W-1];
              sync_sr <= sync_sr << 1;
            end
          end
          S_DATA: begin
            if (bit_idx != DATA_LAST) begin
              bit_idx <= bit_idx + IDX_W'(1);
              dout    <= data_sr[DATA_W-1];
              data_sr <= data_sr << 1;
            end else if (PARITY_EN != 0) begin
              state <= S_PARITY;
              dout  <= parity;
            end else if (GAP_BITS > 0) begin
              state   <= S_GAP;
              bit_idx <= '0;
              dout    <= IDLE_LEVEL;
            end else begin
              state      <= S_IDLE;
              dout       <= IDLE_LEVEL;
              busy       <= 1'b0;
              in_ready   <= 1'b1;
              frame_done <= 1'b1;
            end
          end
          S_PARITY: begin
            if (GAP_BITS > 0) begin
              state   <= S_GAP;
              bit_idx <= '0;
              dout    <= IDLE_LEVEL;
            end else begin
              state      <= S_IDLE;
              dout       <= IDLE_LEVEL;
              busy       <= 1'b0;
              in_ready   <= 1'b1;
              frame_done <= 1'b1;
            end
          end
          S_GAP: begin
            if (bit_idx != GAP_LAST) begin
              bit_idx <= bit_idx + IDX_W'(1);
            end else begin
              state      <= S_IDLE;
              dout       <= IDLE_LEVEL;
              busy       <= 1'b0;
              in_ready   <= 1'b1;
              frame_done <= 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
